dec_countdown_ctrl: RTL and testbench

//  Sequencer for the DEC datapath unit: loads a start value, then steps it down by one per enabled cycle.

---
 rtl/dec_ctrl_pkg.sv | 24 ++
 rtl/dec_countdown_ctrl_dec.sv | 21 ++
 rtl/dec_countdown_ctrl.sv | 129 ++++++++++++
 tb/tb_dec_countdown_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dec_ctrl_pkg.sv
// ============================================================================
// Package : dec_ctrl_pkg
// Purpose : Shared state encoding for the DEC countdown sequencer.
//           The state codes are fixed numeric constants, so status decode
//           outside this block can rely on them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } dec_state_t;

endpackage : dec_ctrl_pkg

`default_nettype wire

// File: rtl/dec_countdown_ctrl_dec.sv
// ============================================================================
// Module  : DEC
// Purpose : Combinational decrement-by-one datapath unit.
// Ports   : a  in  DATAWIDTH  operand
//           d  out DATAWIDTH  a - 1 (modulo 2**DATAWIDTH)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module DEC #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] d
);

  assign d = a - DATAWIDTH'(1);

endmodule : DEC

`default_nettype wire

// File: rtl/dec_countdown_ctrl.sv
// ============================================================================
// Module  : dec_countdown_ctrl
// Purpose : Loads a start value and steps it down by one per enabled cycle
//           through a DEC instance; reports busy/done to a scheduler FSM.
// Ports   : Clk       in   clock, rising edge
//           Rst       in   synchronous active-high reset
//           start     in   launch from load_val (honoured in IDLE/DONE)
//           load_val  in   initial count
//           en        in   step enable (0 = pause)
//           abort     in   cancel countdown, no done
//           count     out  current count (registered)
//           busy      out  high while in RUN
//           done      out  registered one-cycle completion pulse
// Config  : AUTO_RELOAD_EN - when defined, the countdown reloads the value
//           captured at start and keeps running instead of going to DONE.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_countdown_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] load_val,
  input  logic                 en,
  input  logic                 abort,
  output logic [DATAWIDTH-1:0] count,
  output logic                 busy,
  output logic                 done
);

  dec_state_t            r_state;
  dec_state_t            w_state_nxt;
  logic [DATAWIDTH-1:0]  r_count;
  logic [DATAWIDTH-1:0]  w_count_nxt;
  logic [DATAWIDTH-1:0]  w_count_dec;
  logic                  r_done;
  logic                  w_done_nxt;
`ifdef AUTO_RELOAD_EN
  logic [DATAWIDTH-1:0]  r_reload;
  logic                  w_capture;
`endif

  // The only subtractor in the block.
  DEC #(.DATAWIDTH(DATAWIDTH)) u_dec (
    .a (r_count),
    .d (w_count_dec)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_done   <= w_done_nxt;
`ifdef AUTO_RELOAD_EN
      if (w_capture) r_reload <= load_val;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
`ifdef AUTO_RELOAD_EN
    w_capture   = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE falls back to IDLE unless a launch arrives in the same cycle,
        // which gives back-to-back countdowns without an idle bubble.
        if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
        if (start && !abort) begin
`ifdef AUTO_RELOAD_EN
          w_capture = 1'b1;
`endif
          if (load_val != '0) begin
            w_count_nxt = load_val;
            w_state_nxt = ST_RUN;
          end else begin
            w_count_nxt = '0;
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (en) begin
          if (r_count > DATAWIDTH'(1)) begin
            w_count_nxt = w_count_dec;
          end else begin
            // Final step: the 1 -> 0 transition is forced here so the DEC
            // output is never used on a zero operand.
            w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
            w_count_nxt = r_reload;
`else
            w_count_nxt = '0;
            w_state_nxt = ST_DONE;
`endif
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;

endmodule : dec_countdown_ctrl

`default_nettype wire

// File: tb/tb_dec_countdown_ctrl.sv
// ============================================================================
// Module  : tb_dec_countdown_ctrl
// Purpose : Directed self-checking bench for dec_countdown_ctrl.
// Config  : AUTO_RELOAD_EN selects the reload scenario instead of the
//           stop-at-zero scenarios.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_countdown_ctrl;

  localparam int DATAWIDTH = 8;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b1;
  logic                 start = 1'b0;
  logic [DATAWIDTH-1:0] load_val = '0;
  logic                 en = 1'b0;
  logic                 abort = 1'b0;
  logic [DATAWIDTH-1:0] count;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;

  dec_countdown_ctrl #(.DATAWIDTH(DATAWIDTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect3(input string tag, input int c, input int b, input int d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    int exp;

    // 1: reset
    Rst = 1'b1;
    step();
    step();
    expect3("rst_hold", 0, 0, 0);
    Rst = 1'b0;
    step();
    expect3("rst_rel", 0, 0, 0);

    // 4a: zero-length launch
    start = 1'b1; load_val = 8'd0; en = 1'b1;
    step();
    start = 1'b0;
    expect3("zero_done", 0, 0, 1);
    step();
    expect3("zero_idle", 0, 0, 0);

`ifndef AUTO_RELOAD_EN
    // 2: N=5 straight run
    start = 1'b1; load_val = 8'd5; en = 1'b1;
    step();
    start = 1'b0;
    expect3("n5_load", 5, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      expect3("n5_run", i, 1, 0);
    end
    step();
    expect3("n5_done", 0, 0, 1);
    step();
    expect3("n5_idle", 0, 0, 0);

    // 3: N=10 with en toggling
    start = 1'b1; load_val = 8'd10; en = 1'b1;
    step();
    start = 1'b0;
    expect3("n10_load", 10, 1, 0);
    exp = 10;
    for (int i = 0; i < 19; i++) begin
      en = (i % 2 == 0);
      step();
      if (i % 2 == 0) exp--;
      expect3("n10_step", exp, (exp != 0) ? 1 : 0, (exp == 0) ? 1 : 0);
    end
    en = 1'b1;
    step();
    expect3("n10_idle", 0, 0, 0);

    // 4b: start during RUN is ignored
    start = 1'b1; load_val = 8'd4;
    step();
    expect3("ign_load", 4, 1, 0);
    load_val = 8'd9;
    step();
    expect3("ign_start", 3, 1, 0);
    start = 1'b0;
    step();
    expect3("ign_2", 2, 1, 0);
    step();
    expect3("ign_1", 1, 1, 0);
    // back-to-back launch from DONE
    start = 1'b1; load_val = 8'd2;
    step();
    expect3("b2b_done", 0, 0, 1);
    step();
    start = 1'b0;
    expect3("b2b_load", 2, 1, 0);
    step();
    step();
    expect3("b2b_done2", 0, 0, 1);
    step();

    // 5: abort at count 3
    start = 1'b1; load_val = 8'd8;
    step();
    start = 1'b0;
    expect3("ab_load", 8, 1, 0);
    for (int i = 7; i >= 3; i--) step();
    expect3("ab_pre", 3, 1, 0);
    abort = 1'b1;
    step();
    expect3("ab_idle", 3, 0, 0);
    start = 1'b1; load_val = 8'd6;
    step();
    expect3("ab_beats_start", 3, 0, 0);
    abort = 1'b0; start = 1'b0;
    step();
    expect3("ab_hold", 3, 0, 0);
    // pause in RUN holds count
    start = 1'b1; load_val = 8'd3; en = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    expect3("pause", 3, 1, 0);
`else
    // 6: auto-reload
    start = 1'b1; load_val = 8'd3; en = 1'b1;
    step();
    start = 1'b0;
    expect3("rl_load", 3, 1, 0);
    for (int lap = 0; lap < 2; lap++) begin
      step();
      expect3("rl_2", 2, 1, 0);
      step();
      expect3("rl_1", 1, 1, 0);
      step();
      expect3("rl_reload", 3, 1, 1);
    end
    step();
    expect3("rl_after", 2, 1, 0);
    Rst = 1'b1;
    step();
    expect3("rl_rst", 0, 0, 0);
    Rst = 1'b0;
    step();
    expect3("rl_rst_rel", 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_dec_countdown_ctrl

`default_nettype wire
